mod5_check_serializer: RTL and testbench
========================================

# mod5_check_serializer

Parallel-to-serial transmitter that drives the MSB-first bitstream consumed by the serial divisible-by-5 detector. The block accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, MSB first. It tracks the running remainder mod 5 using the same transition rule as the detector. It optionally appends a 3-bit check field so that the complete transmitted frame, read as a binary number, is divisible by 5.

## Interface
- WIDTH, 8: data word width; legal range ≥ 1.
- CHECK_EN, 1: 1 appends the 3-bit mod-5 check field; 0 sends data bits only.

- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  word offered on load_data.
- load_data  in  WIDTH  word to transmit.
- load_ready  out  1  block can accept a word; equals (state==IDLE) && reset_n.
- dout  out  1  serial data bit; 0 whenever dout_valid=0.
- dout_valid  out  1  dout carries a frame bit this cycle.
- frame_last  out  1  current bit is the final bit of the frame.
- rem  out  3  remainder mod 5 of all frame bits emitted before the current cycle; range 0..4.

## Operation
- States:
  - IDLE: load_ready=1.
  - DATA: shifting the word.
  - CHECK: shifting the check field; only reached when CHECK_EN=1.
- IDLE → DATA on an edge with load_valid && load_ready:
  - shift register ← load_data.
  - bit counter ← WIDTH-1.
  - rem ← 0.
- DATA: one data bit per cycle, MSB first.
  - After the bit at index 0: go to CHECK if CHECK_EN=1, else go to IDLE.
- Remainder update: on every edge where dout_valid=1, rem ← (2·rem + dout) mod 5. This uses the detector's transitions: 0→{0,1}, 1→{2,3}, 2→{4,0}, 3→{1,2}, 4→{3,4} for dout={0,1}.
- Check field: c = (2·r) mod 5, where r is the remainder after the last data bit. The mapping r→c is 0→0, 1→2, 2→4, 3→1, 4→3.
  - c is emitted as 3 bits, MSB first.
  - Property: value·8 + c ≡ 0 (mod 5).
- frame_last is asserted on:
  - the third check bit (CHECK_EN=1), or
  - data bit 0 (CHECK_EN=0).
- After frame_last the block returns to IDLE. rem holds its final value until the next load.
- load_valid while load_ready=0 is ignored. The word is not captured and the frame in flight is unaffected.
- Arithmetic: the remainder is computed in a 4-bit intermediate (max 2·4+1=9) and reduced with a single conditional subtract of 5.

## Timing
- All outputs except load_ready are registered.
- Reset values while reset_n=0: state IDLE, dout=0, dout_valid=0, frame_last=0, rem=0, load_ready=0.
- After reset_n rises, load_ready=1 immediately, since load_ready is combinational from state.
- For a load accepted at edge k:
  - data bit WIDTH-1-i is valid in cycle k+1+i, for i = 0..WIDTH-1.
  - check bits are valid in cycles k+WIDTH+1 .. k+WIDTH+3.
- Frame length is WIDTH+3 cycles (CHECK_EN=1) or WIDTH cycles (CHECK_EN=0). dout_valid stays continuously high, with no gaps inside a frame.
- rem lags dout by one cycle. With CHECK_EN=1, rem=0 in the cycle after frame_last.
- load_ready returns high in the cycle after frame_last. The minimum inter-frame gap is one idle cycle.
- Reset asserted mid-frame:
  - the frame is abandoned immediately and asynchronously.
  - all outputs go to their reset values.
  - no resume occurs; the next load starts a fresh frame with rem=0.
- WIDTH=1: one data bit. frame_last coincides with that bit when CHECK_EN=0.

## Test plan
- Reset behaviour: hold reset_n low for 3 cycles while load_valid=1 → dout_valid=0, load_ready=0, rem=0, no capture. Release reset_n → load_ready=1; load occurs on the first edge with load_valid=1.
- WIDTH=8, CHECK_EN=1, load 8'd13 → dout sequence 0,0,0,0,1,1,0,1,0,0,1 over 11 cycles (remainder 3, check 001). frame_last only on the 11th bit. rem=0 afterwards (105 = 21·5).
- Load 8'hFF → data bits all 1, remainder 0, check 000. rem=0 after the frame (2040 ≡ 0).
- Load 8'd7 with load_valid held high continuously → first frame ends with check 100 (60 ≡ 0). load_valid during the frame is ignored. The second frame starts exactly one idle cycle after frame_last.
- Load 8'd200, then drive reset_n low after the 4th bit → outputs clear the same cycle. After release, load 8'd3 → clean frame 0,0,0,0,0,0,1,1 followed by check 001.
- WIDTH=1, CHECK_EN=0, load 1'b1 → single cycle with dout=1, dout_valid=1, frame_last=1. rem=1 in the next cycle; load_ready high in the next cycle.

Source files
------------

// File: rtl/mod5_check_serializer.sv
// MSB-first parallel-to-serial transmitter with a running mod-5 remainder and an
// optional 3-bit check field that makes the whole frame divisible by 5.
module mod5_check_serializer #(
  parameter int WIDTH    = 8,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_last,
  output logic [2:0]       rem,
  output logic [1:0]       dbg_state
);

  // Handshake: a word transfers on a rising edge where load_valid && load_ready;
  // load_valid while load_ready=0 is ignored and nothing is captured.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       chk_q, chk_d;
  logic [1:0]       chk_cnt_q, chk_cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_last_q, frame_last_d;
  logic [2:0]       rem_q, rem_d;
  logic [2:0]       rem_next;
  logic [2:0]       check_val;

  // (2*r + b) mod 5 with a single conditional subtract; max intermediate is 9.
  function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
    logic [3:0] t;
    t = {r, 1'b0} + {3'b000, b};
    if (t >= 4'd5) t = t - 4'd5;
    return t[2:0];
  endfunction

  assign rem_next  = mod5_step(rem_q, dout_q);
  // Check value is (2*r) mod 5, i.e. one more step with a zero bit.
  assign check_val = mod5_step(rem_next, 1'b0);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    chk_d        = chk_q;
    chk_cnt_d    = chk_cnt_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    frame_last_d = 1'b0;
    rem_d        = rem_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d      = DATA;
          shift_d      = load_data << 1;
          cnt_d        = CW'(WIDTH - 1);
          dout_d       = load_data[WIDTH-1];
          dout_valid_d = 1'b1;
          frame_last_d = (WIDTH == 1) && !CHECK_EN;
          rem_d        = 3'd0;
        end
      end
      DATA: begin
        rem_d = rem_next;
        if (cnt_q == '0) begin
          if (CHECK_EN) begin
            state_d      = CHECK;
            dout_d       = check_val[2];
            chk_d        = {check_val[1:0], 1'b0};
            chk_cnt_d    = 2'd2;
            dout_valid_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dout_d       = shift_q[WIDTH-1];
          shift_d      = shift_q << 1;
          cnt_d        = cnt_q - CW'(1);
          dout_valid_d = 1'b1;
          frame_last_d = (cnt_q == CW'(1)) && !CHECK_EN;
        end
      end
      CHECK: begin
        rem_d = rem_next;
        if (chk_cnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          dout_d       = chk_q[2];
          chk_d        = {chk_q[1:0], 1'b0};
          chk_cnt_d    = chk_cnt_q - 2'd1;
          dout_valid_d = 1'b1;
          frame_last_d = (chk_cnt_q == 2'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      chk_q        <= 3'd0;
      chk_cnt_q    <= 2'd0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      frame_last_q <= 1'b0;
      rem_q        <= 3'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      chk_q        <= chk_d;
      chk_cnt_q    <= chk_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_last_q <= frame_last_d;
      rem_q        <= rem_d;
    end
  end

  assign load_ready = (state_q == IDLE) && reset_n;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_last = frame_last_q;
  assign rem        = rem_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mod5_check_serializer.sv
// Directed bench for mod5_check_serializer: WIDTH=8/CHECK_EN=1 and WIDTH=1/CHECK_EN=0.
module tb_mod5_check_serializer;

  logic       clk;
  logic       reset_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready, dout, dout_valid, frame_last;
  logic [2:0] rem;
  logic [1:0] dbg_state;

  logic       load_valid1;
  logic [0:0] load_data1;
  logic       load_ready1, dout1, dout_valid1, frame_last1;
  logic [2:0] rem1;
  logic [1:0] dbg_state1;

  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  mod5_check_serializer #(.WIDTH(8), .CHECK_EN(1'b1)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid),
    .frame_last(frame_last), .rem(rem), .dbg_state(dbg_state)
  );

  mod5_check_serializer #(.WIDTH(1), .CHECK_EN(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid1), .load_data(load_data1),
    .load_ready(load_ready1), .dout(dout1), .dout_valid(dout_valid1),
    .frame_last(frame_last1), .rem(rem1), .dbg_state(dbg_state1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one word into the 8-bit instance and checks every frame bit against the
  // scoreboard; abort_after>0 asserts reset right after that many bits.
  task automatic send_frame(input logic [7:0] value, input bit hold, input int abort_after);
    int         prefix;
    logic [0:0] b;
    logic [2:0] c;
    c = 3'(((value % 5) * 2) % 5);
    for (int i = 7; i >= 0; i--) exp_q.push_back(value[i]);
    exp_q.push_back(c[2]);
    exp_q.push_back(c[1]);
    exp_q.push_back(c[0]);
    load_valid = 1'b1;
    load_data  = value;
    @(posedge clk); #1;
    if (!hold) load_valid = 1'b0;
    prefix = 0;
    for (int i = 0; i < 11; i++) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
        return;
      end
      b = exp_q.pop_front();
      chk($sformatf("bit%0d_valid", i), dout_valid, 1);
      chk($sformatf("bit%0d_dout", i), dout, b);
      chk($sformatf("bit%0d_last", i), frame_last, (i == 10));
      chk($sformatf("bit%0d_rem", i), rem, prefix % 5);
      chk($sformatf("bit%0d_ready", i), load_ready, 0);
      prefix = prefix * 2 + int'(b);
      if (abort_after != 0 && i == abort_after - 1) begin
        reset_n = 1'b0;
        #1;
        chk("abort_valid", dout_valid, 0);
        chk("abort_dout", dout, 0);
        chk("abort_last", frame_last, 0);
        chk("abort_rem", rem, 0);
        chk("abort_ready", load_ready, 0);
        exp_q.delete();
        return;
      end
      @(posedge clk); #1;
    end
    chk("end_valid", dout_valid, 0);
    chk("end_last", frame_last, 0);
    chk("end_rem", rem, prefix % 5);
    chk("end_ready", load_ready, 1);
  endtask

  initial begin
    reset_n     = 1'b0;
    load_valid  = 1'b1;
    load_data   = 8'd99;
    load_valid1 = 1'b0;
    load_data1  = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_last", frame_last, 0);
      chk("rst_rem", rem, 0);
      chk("rst_ready", load_ready, 0);
    end
    load_valid = 1'b0;
    reset_n    = 1'b1;
    #1;
    chk("rel_ready", load_ready, 1);
    @(posedge clk); #1;
    chk("rel_no_capture", dout_valid, 0);

    send_frame(8'd13, 1'b0, 0);
    send_frame(8'hFF, 1'b0, 0);
    send_frame(8'd7, 1'b1, 0);
    send_frame(8'd7, 1'b0, 0);

    send_frame(8'd200, 1'b0, 4);
    @(posedge clk); #1;
    chk("inrst_valid", dout_valid, 0);
    chk("inrst_rem", rem, 0);
    reset_n = 1'b1;
    #1;
    chk("after_abort_ready", load_ready, 1);
    send_frame(8'd3, 1'b0, 0);

    load_valid1 = 1'b1;
    load_data1  = 1'b1;
    @(posedge clk); #1;
    load_valid1 = 1'b0;
    chk("w1_dout", dout1, 1);
    chk("w1_valid", dout_valid1, 1);
    chk("w1_last", frame_last1, 1);
    chk("w1_rem", rem1, 0);
    chk("w1_ready", load_ready1, 0);
    @(posedge clk); #1;
    chk("w1_rem_after", rem1, 1);
    chk("w1_ready_after", load_ready1, 1);
    chk("w1_valid_after", dout_valid1, 0);
    chk("w1_last_after", frame_last1, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
